// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - ALU execute stage with iterative one-bit-per-cycle shifter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented        in_ready  block can accept (IDLE only)
//   alu_ctrl   4-bit operation code       op_a/op_b WIDTH-bit operands
//   out_valid  result available           out_ready consumer takes result
//   result     operation result           zero      result == 0 (with out_valid)
//   err        reserved code executed
module alu_iter_exec #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ANDN = 4'b0011;
    localparam logic [3:0] OP_BTR  = 4'b1000;
    localparam logic [3:0] OP_SEQ  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLE  = 4'b1011;
    localparam logic [3:0] OP_SCO  = 4'b1100;
    localparam logic [3:0] OP_LBI  = 4'b1101;
    localparam logic [3:0] OP_SLBI = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    // Low two code bits of the 01xx shift group select the direction.
    localparam logic [1:0] SH_ROL = 2'b00;
    localparam logic [1:0] SH_SLL = 2'b01;
    localparam logic [1:0] SH_ROR = 2'b10;
    localparam logic [1:0] SH_SRL = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   RES_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]         dir_q,   dir_d;
    logic               err_q,   err_d;

    logic               is_shift;
    logic [SHAMT_W-1:0] amt;

    // Single-cycle result. Shift codes return A unchanged, which is exactly
    // the shift-by-zero result; nonzero shifts never use this value.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       code,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        sum = {1'b0, a} + {1'b0, b};
        r   = '0;
        case (code)
            OP_ADD:  r = sum[WIDTH-1:0];
            OP_SUB:  r = b - a;
            OP_XOR:  r = a ^ b;
            OP_ANDN: r = a & ~b;
            OP_BTR: begin
                for (int i = 0; i < WIDTH; i++) begin
                    r[WIDTH-1-i] = a[i];
                end
            end
            OP_SEQ:  r[0] = (a == b);
            OP_SLT:  r[0] = ($signed(a) < $signed(b));
            OP_SLE:  r[0] = ($signed(a) <= $signed(b));
            OP_SCO:  r[0] = sum[WIDTH];
            OP_LBI:  r = b;
            OP_SLBI: r = (a << 8) | {{(WIDTH-8){1'b0}}, b[7:0]};
            OP_RSVD: r = '0;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(
        input logic [1:0]       dir,
        input logic [WIDTH-1:0] w
    );
        logic [WIDTH-1:0] r;
        case (dir)
            SH_ROL:  r = {w[WIDTH-2:0], w[WIDTH-1]};
            SH_SLL:  r = {w[WIDTH-2:0], 1'b0};
            SH_ROR:  r = {w[0], w[WIDTH-1:1]};
            SH_SRL:  r = {1'b0, w[WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign is_shift = (alu_ctrl[3:2] == 2'b01);
    assign amt      = op_b[SHAMT_W-1:0];

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dir_d = alu_ctrl[1:0];
                    if (is_shift && amt != CNT_ZERO) begin
                        // res_q doubles as the shifter's working register.
                        state_d = S_SHIFT;
                        res_d   = op_a;
                        cnt_d   = amt;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_single(alu_ctrl, op_a, op_b);
                        err_d   = (alu_ctrl == OP_RSVD);
                    end
                end
            end
            S_SHIFT: begin
                res_d = shift_one(dir_q, res_q);
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Gating with rst_n keeps in_ready low for the whole reset assertion.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign zero      = out_valid && (res_q == RES_ZERO);
    assign err       = err_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - self-checking bench for alu_iter_exec
module tb_alu_iter_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero;
    logic        err;

    int total = 0;
    int bad   = 0;

    alu_iter_exec #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  c;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the operation table, using 32-bit ints.
    function automatic void model(input logic [3:0] c, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic e, output int lat);
        int unsigned ua, ub, n, t;
        int          sa, sb;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        n  = ub % 16;
        e  = 1'b0;
        lat = 1;
        t  = 0;
        case (c)
            4'd0:  t = ua + ub;
            4'd1:  t = ub - ua;
            4'd2:  t = ua ^ ub;
            4'd3:  t = ua & ~ub;
            4'd4:  t = (ua << n) | (ua >> (16 - n));
            4'd5:  t = ua << n;
            4'd6:  t = (ua >> n) | (ua << (16 - n));
            4'd7:  t = ua >> n;
            4'd8:  for (int i = 0; i < 16; i++) if (a[i]) t += (1 << (15 - i));
            4'd9:  t = (ua == ub) ? 1 : 0;
            4'd10: t = (sa < sb) ? 1 : 0;
            4'd11: t = (sa <= sb) ? 1 : 0;
            4'd12: t = ((ua + ub) > 65535) ? 1 : 0;
            4'd13: t = ub;
            4'd14: t = ua * 256 + (ub % 256);
            default: begin t = 0; e = 1'b1; end
        endcase
        if (c >= 4 && c <= 7) lat = int'(n) + 1;
        r = t[15:0];
    endfunction

    // Issue one op, scramble inputs after accept, measure latency, consume.
    task automatic do_op(input string name, input logic [3:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic ee,
                         input int elat);
        int lat;
        int busy_ready;
        @(negedge clk);
        chk({name, " in_ready idle"}, int'(in_ready), 1);
        in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
        lat = 1;
        busy_ready = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ready = 1;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " out_valid"}, int'(out_valid), 1);
        chk({name, " latency"}, lat, elat);
        chk({name, " in_ready busy"}, busy_ready + int'(in_ready), 0);
        chk({name, " result"}, int'(result), int'(er));
        chk({name, " zero"}, int'(zero), (er == 16'h0) ? 1 : 0);
        chk({name, " err"}, int'(err), int'(ee));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " out_valid drop"}, int'(out_valid), 0);
        chk({name, " err clear"}, int'(err), 0);
    endtask

    initial begin
        logic [15:0] mr;
        logic        me;
        int          ml;
        logic [15:0] held;

        vecs[0]  = '{"ADD",  4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1};
        vecs[1]  = '{"SUB",  4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1};
        vecs[2]  = '{"SLT",  4'hA, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1};
        vecs[3]  = '{"SCO",  4'hC, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1};
        vecs[4]  = '{"SEQ",  4'h9, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1};
        vecs[5]  = '{"SLE",  4'hB, 16'h0002, 16'h0001, 16'h0000, 1'b0, 1};
        vecs[6]  = '{"ROL",  4'h4, 16'h8001, 16'h0004, 16'h0018, 1'b0, 5};
        vecs[7]  = '{"SRL",  4'h7, 16'h8000, 16'h000F, 16'h0001, 1'b0, 16};
        vecs[8]  = '{"SLL0", 4'h5, 16'h1234, 16'hFFF0, 16'h1234, 1'b0, 1};
        vecs[9]  = '{"BTR",  4'h8, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1};
        vecs[10] = '{"SLBI", 4'hE, 16'h00AB, 16'hFFCD, 16'hABCD, 1'b0, 1};
        vecs[11] = '{"LBI",  4'hD, 16'h1111, 16'hFF80, 16'hFF80, 1'b0, 1};
        vecs[12] = '{"RSVD", 4'hF, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1};
        vecs[13] = '{"ROR",  4'h6, 16'h0001, 16'h0013, 16'h2000, 1'b0, 4};
        vecs[14] = '{"XOR",  4'h2, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1};
        vecs[15] = '{"ANDN", 4'h3, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1};
        vecs[16] = '{"SLL15",4'h5, 16'hFFFF, 16'h000F, 16'h8000, 1'b0, 16};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'h0; op_a = 16'h0; op_b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result", int'(result), 0);
        chk("reset zero", int'(zero), 0);
        chk("reset err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", int'(in_ready), 1);

        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].c, vecs[i].a, vecs[i].b,
                  vecs[i].r, vecs[i].e, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  rc;
            logic [15:0] ra, rb;
            rc = 4'($urandom); ra = 16'($urandom); rb = 16'($urandom);
            if (i % 4 == 0) rb = rb & 16'h8000;
            model(rc, ra, rb, mr, me, ml);
            do_op($sformatf("rand%0d_c%0h", i, rc), rc, ra, rb, mr, me, ml);
        end

        // Backpressure: result must hold while inputs churn and in_valid stays high.
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'h0; op_a = 16'h1000; op_b = 16'h0234;
        @(posedge clk); #1;
        chk("bp out_valid", int'(out_valid), 1);
        held = result;
        chk("bp result", int'(held), 16'h1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_a = 16'($urandom); op_b = 16'($urandom); alu_ctrl = 4'($urandom);
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d", i),
                int'(result == held && out_valid && !in_ready), 1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release out_valid", int'(out_valid), 0);
        chk("bp release in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp no second accept", int'(out_valid), 0);

        // Reset three cycles into a ROR by 10.
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'h6; op_a = 16'hBEEF; op_b = 16'h000A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst result", int'(result), 0);
        chk("midrst in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst no stale result", int'(out_valid), 0);
        do_op("ADD after reset", 4'h0, 16'h0100, 16'h0023, 16'h0123, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
